// File: rtl/operand_fetch_if.sv
// operand_fetch_if: start/instruction/memory-read/result bundle between the fetch sequencer, memory and operand_fetch
interface operand_fetch_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic [31:0]           ir;
  logic [DATA_WIDTH-1:0] mem_in;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  busy;
  logic                  done;
  logic                  illegal;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [DATA_WIDTH-1:0] src1;
  logic [DATA_WIDTH-1:0] src2;
  modport master (
    output start, ir, mem_in,
    input  mem_addr, busy, done, illegal, dst_addr, src1, src2
  );
  modport slave (
    input  start, ir, mem_in,
    output mem_addr, busy, done, illegal, dst_addr, src1, src2
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: resolves instruction operands through memory (direct, or indirect when
// OPERAND_FETCH_INDIRECT_EN is defined) and hands dst_addr/src1/src2 to execute with a done strobe
module operand_fetch #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  operand_fetch_if.slave bus
);
`ifdef OPERAND_FETCH_INDIRECT_EN
  localparam bit IND_EN = 1'b1;
`else
  localparam bit IND_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;
  state_t                r_state;
  logic [31:0]           r_ir;
  logic [5:0]            r_need;
  logic [2:0]            r_slot;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH-1:0] r_dst_addr;
  logic [DATA_WIDTH-1:0] r_src1;
  logic [DATA_WIDTH-1:0] r_src2;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_illegal;
  logic [5:0]            w_need_in;
  logic [5:0]            w_left;
  logic [3:0]            w_field;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [31:0]           w_fin_ir;
  logic                  w_fin;
  function automatic logic ind(input logic b);
    return IND_EN && b;
  endfunction
  function automatic logic is_alu(input logic [3:0] op);
    return op >= 4'd3 && op <= 4'd6;
  endfunction
  function automatic logic mov_imm(input logic [31:0] ir);
    return ir[31:28] == 4'd0 && ir[19:16] == 4'b1000;
  endfunction
  function automatic logic a_dst(input logic [3:0] op);
    return op <= 4'd1 || is_alu(op);
  endfunction
  // Read slots, bit order = fetch order: {C_val, C_ptr, B_val, B_ptr, A_val, A_ptr}
  function automatic logic [5:0] need_of(input logic [31:0] ir);
    logic a_src;
    logic b_src;
    logic c_src;
    a_src = ir[31:28] == 4'd2;
    b_src = is_alu(ir[31:28]) || (ir[31:28] == 4'd0 && !mov_imm(ir));
    c_src = is_alu(ir[31:28]);
    return {c_src, c_src && ind(ir[19]), b_src, b_src && ind(ir[23]),
            a_src, (a_dst(ir[31:28]) || a_src) && ind(ir[27])};
  endfunction
  function automatic logic [2:0] first_set(input logic [5:0] m);
    logic [2:0] f;
    f = 3'd0;
    for (int i = 5; i >= 0; i--) if (m[i]) f = 3'(i);
    return f;
  endfunction
  assign w_need_in = need_of(bus.ir);
  assign w_left    = r_need & ~(6'd1 << r_slot);
  assign w_field   = r_slot[2:1] == 2'd0 ? r_ir[27:24] : r_slot[2:1] == 2'd1 ? r_ir[23:20] : r_ir[19:16];
  // Pointer slots and direct value slots address the field itself; indirect value slots use the captured pointer
  assign w_addr    = (!r_slot[0] || !ind(w_field[3])) ? ADDR_WIDTH'(w_field[2:0]) : r_ptr;
  assign w_fin_ir  = r_state == IDLE ? bus.ir : r_ir;
  assign w_fin     = (r_state == IDLE && bus.start && w_need_in == 6'd0) || (r_state == CAPTURE && w_left == 6'd0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ir       <= '0;
      r_need     <= '0;
      r_slot     <= '0;
      r_ptr      <= '0;
      r_mem_addr <= '0;
      r_dst_addr <= '0;
      r_src1     <= '0;
      r_src2     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_ir       <= bus.ir;
          r_need     <= w_need_in;
          r_slot     <= first_set(w_need_in);
          r_dst_addr <= '0;
          r_src1     <= '0;
          r_src2     <= '0;
          r_illegal  <= 1'b0;
          r_busy     <= 1'b1;
          r_state    <= w_need_in != 6'd0 ? ISSUE : DONE;
        end
        ISSUE: begin
          r_mem_addr <= w_addr;
          r_state    <= WAIT;
        end
        WAIT: r_state <= CAPTURE;
        CAPTURE: begin
          if (!r_slot[0]) r_ptr <= bus.mem_in[ADDR_WIDTH-1:0];
          if (r_slot == 3'd0 && !r_need[1]) r_dst_addr <= bus.mem_in[ADDR_WIDTH-1:0];
          if (r_slot == 3'd1 || r_slot == 3'd3) r_src1 <= bus.mem_in;
          if (r_slot == 3'd5) r_src2 <= bus.mem_in;
          r_need  <= w_left;
          r_slot  <= first_set(w_left);
          r_state <= w_left != 6'd0 ? ISSUE : DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // Results that need no read are resolved on entry to DONE
      if (w_fin) begin
        r_done    <= 1'b1;
        r_illegal <= w_fin_ir[31];
        if (a_dst(w_fin_ir[31:28]) && !ind(w_fin_ir[27])) r_dst_addr <= ADDR_WIDTH'(w_fin_ir[26:24]);
        if (mov_imm(w_fin_ir)) r_src1 <= DATA_WIDTH'(w_fin_ir[15:0]);
      end
    end
  end
  assign bus.mem_addr = r_mem_addr;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.illegal  = r_illegal;
  assign bus.dst_addr = r_dst_addr;
  assign bus.src1     = r_src1;
  assign bus.src2     = r_src2;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: randomized and directed checks of operand_fetch against an operand-resolution model
module tb_operand_fetch;
`ifdef OPERAND_FETCH_INDIRECT_EN
  localparam bit IND_EN = 1'b1;
`else
  localparam bit IND_EN = 1'b0;
`endif
  logic clk;
  logic rst_n;
  int checks;
  int errors;
  int r_lat;
  logic [15:0] mem [64];
  logic [5:0]  m_dst;
  logic [15:0] m_s1;
  logic [15:0] m_s2;
  logic        m_ill;
  int          m_n;
  operand_fetch_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus();
  operand_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) bus.mem_in <= mem[bus.mem_addr];
  task automatic locate(input logic [3:0] f, output logic [5:0] loc);
    if (IND_EN && f[3]) begin
      loc = mem[f[2:0]][5:0];
      m_n++;
    end else loc = {3'b000, f[2:0]};
  endtask
  task automatic fetch(input logic [3:0] f, output logic [15:0] v);
    logic [5:0] l;
    locate(f, l);
    v = mem[l];
    m_n++;
  endtask
  task automatic model(input logic [31:0] ir);
    logic [3:0] op;
    op = ir[31:28];
    m_dst = 0; m_s1 = 0; m_s2 = 0; m_n = 0; m_ill = op >= 8;
    if (op == 0) begin
      locate(ir[27:24], m_dst);
      if (ir[19:16] == 4'b1000) m_s1 = ir[15:0];
      else fetch(ir[23:20], m_s1);
    end else if (op == 1) locate(ir[27:24], m_dst);
    else if (op == 2) fetch(ir[27:24], m_s1);
    else if (op >= 3 && op <= 6) begin
      locate(ir[27:24], m_dst);
      fetch(ir[23:20], m_s1);
      fetch(ir[19:16], m_s2);
    end
  endtask
  task automatic run_op(input logic [31:0] ir, input bit perturb);
    int k;
    logic [5:0] a0;
    model(ir);
    @(negedge clk);
    a0 = bus.mem_addr;
    bus.ir = ir;
    bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_after_start ir=%h got %b want 1", ir, bus.busy); end
    k = 0;
    while (bus.done !== 1'b1 && k < 200) begin
      if (perturb) begin bus.start = 1'($urandom); bus.ir = $urandom; end
      @(posedge clk); #1;
      k++;
    end
    r_lat = k;
    checks++; if (k != 3 * m_n) begin errors++; $display("FAIL latency ir=%h got %0d want %0d", ir, k, 3 * m_n); end
    checks++; if (bus.dst_addr !== m_dst) begin errors++; $display("FAIL dst_addr ir=%h got %h want %h", ir, bus.dst_addr, m_dst); end
    checks++; if (bus.src1 !== m_s1) begin errors++; $display("FAIL src1 ir=%h got %h want %h", ir, bus.src1, m_s1); end
    checks++; if (bus.src2 !== m_s2) begin errors++; $display("FAIL src2 ir=%h got %h want %h", ir, bus.src2, m_s2); end
    checks++; if (bus.illegal !== m_ill) begin errors++; $display("FAIL illegal ir=%h got %b want %b", ir, bus.illegal, m_ill); end
    if (m_n == 0) begin
      checks++; if (bus.mem_addr !== a0) begin errors++; $display("FAIL mem_addr_hold ir=%h got %h want %h", ir, bus.mem_addr, a0); end
    end
    if (perturb) bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_one_cycle ir=%h got %b want 0", ir, bus.done); end
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL idle_after_done ir=%h got busy=%b done=%b want 0 0", ir, bus.busy, bus.done); end
    checks++; if (bus.dst_addr !== m_dst || bus.src1 !== m_s1 || bus.src2 !== m_s2) begin errors++; $display("FAIL results_hold ir=%h got %h %h %h want %h %h %h", ir, bus.dst_addr, bus.src1, bus.src2, m_dst, m_s1, m_s2); end
  endtask
  task automatic test_reset();
    rst_n = 0; bus.start = 0; bus.ir = 0;
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({bus.busy, bus.done, bus.illegal, bus.dst_addr, bus.src1, bus.src2, bus.mem_addr} !== '0) begin errors++; $display("FAIL reset_outputs got busy=%b done=%b ill=%b dst=%h s1=%h s2=%h ma=%h want all 0", bus.busy, bus.done, bus.illegal, bus.dst_addr, bus.src1, bus.src2, bus.mem_addr); end
    @(negedge clk); rst_n = 1;
  endtask
  task automatic test_add();
    mem[1] = 16'd5; mem[2] = 16'd7;
    run_op(32'h3012_0000, 0);
    checks++; if (r_lat != 6 || bus.src1 !== 16'd5 || bus.src2 !== 16'd7 || bus.dst_addr !== 6'd0) begin errors++; $display("FAIL add_direct got lat=%0d s1=%h s2=%h dst=%h want 6 0005 0007 00", r_lat, bus.src1, bus.src2, bus.dst_addr); end
  endtask
  task automatic test_mov_imm();
    run_op(32'h0308_1234, 0);
    checks++; if (r_lat != 0 || bus.src1 !== 16'h1234 || bus.dst_addr !== 6'd3 || bus.src2 !== 16'd0) begin errors++; $display("FAIL mov_imm got lat=%0d s1=%h dst=%h s2=%h want 0 1234 03 0000", r_lat, bus.src1, bus.dst_addr, bus.src2); end
  endtask
  task automatic test_indirect();
    mem[1] = 16'h0020; mem[6'h20] = 16'd9; mem[2] = 16'h0011;
    run_op(32'h4A92_0000, 0);
    if (IND_EN) begin
      checks++; if (r_lat != 12 || bus.dst_addr !== 6'h11 || bus.src1 !== 16'd9 || bus.src2 !== 16'h0011) begin errors++; $display("FAIL sub_indirect got lat=%0d dst=%h s1=%h s2=%h want 12 11 0009 0011", r_lat, bus.dst_addr, bus.src1, bus.src2); end
    end else begin
      checks++; if (r_lat != 6 || bus.dst_addr !== 6'd2 || bus.src1 !== 16'h0020 || bus.src2 !== 16'h0011) begin errors++; $display("FAIL sub_no_indirect got lat=%0d dst=%h s1=%h s2=%h want 6 02 0020 0011", r_lat, bus.dst_addr, bus.src1, bus.src2); end
    end
  endtask
  task automatic test_illegal();
    run_op(32'h9000_0000, 0);
    checks++; if (r_lat != 0 || bus.illegal !== 1'b1) begin errors++; $display("FAIL illegal_op got lat=%0d ill=%b want 0 1", r_lat, bus.illegal); end
    run_op(32'h7123_4567, 0);
  endtask
  task automatic test_self_ptr();
    mem[3] = 16'h0003; mem[1] = 16'h00A5;
    run_op(32'h31B3_0000, 0);
    run_op(32'h2B00_0000, 0);
  endtask
  task automatic test_back_to_back();
    mem[1] = 16'd5; mem[2] = 16'd7;
    run_op(32'h3012_0000, 1);
    checks++; if (bus.src1 !== 16'd5 || bus.src2 !== 16'd7 || bus.dst_addr !== 6'd0) begin errors++; $display("FAIL back_to_back got s1=%h s2=%h dst=%h want 0005 0007 00", bus.src1, bus.src2, bus.dst_addr); end
  endtask
  task automatic test_random();
    logic [31:0] ir;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
      mem[$urandom_range(0, 63)] = 16'($urandom);
      ir = $urandom;
      if (ir[31:28] == 0 && $urandom_range(0, 3) == 0) ir[19:16] = 4'b1000;
      if ($urandom_range(0, 2) == 0) ir[31:28] = 4'($urandom_range(3, 6));
      run_op(ir, 1'($urandom_range(0, 1)));
    end
  endtask
  task automatic test_abort();
    int seen;
    mem[1] = 16'd5; mem[2] = 16'd7;
    @(negedge clk); bus.ir = 32'h3012_0000; bus.start = 1;
    @(posedge clk); #1; bus.start = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    checks++; if ({bus.busy, bus.done, bus.illegal, bus.dst_addr, bus.src1, bus.src2, bus.mem_addr} !== '0) begin errors++; $display("FAIL abort_outputs got busy=%b done=%b ill=%b dst=%h s1=%h s2=%h ma=%h want all 0", bus.busy, bus.done, bus.illegal, bus.dst_addr, bus.src1, bus.src2, bus.mem_addr); end
    @(negedge clk); rst_n = 1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", seen); end
  endtask
  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_add();
    test_mov_imm();
    test_indirect();
    test_illegal();
    test_self_ptr();
    test_back_to_back();
    test_random();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-and-operand-fetch stage placed directly after the CPU's instruction-fetch sequencer. It takes a latched 32-bit instruction word and resolves its operand fields through memory using direct or indirect addressing. It then hands the execute stage a resolved destination address, up to two source values and a one-cycle `done` strobe. It owns the memory read port while busy and never writes memory.

## Interface
- `ADDR_WIDTH`, default 6: memory address width.
- `DATA_WIDTH`, default 16: memory word width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `ir`  in  32  instruction word, with fields:
  - `[31:28]` opcode
  - `[27:24]` A
  - `[23:20]` B
  - `[19:16]` C
  - `[15:0]` immediate data
- `mem_in`  in  DATA_WIDTH  memory read data.
- `mem_addr`  out  ADDR_WIDTH  registered read address.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle strobe; all result outputs are valid while it is high.
- `illegal`  out  1  valid with `done`; set when opcode is 8..15.
- `dst_addr`  out  ADDR_WIDTH  resolved address of operand A.
- `src1`, `src2`  out  DATA_WIDTH  resolved source values.

## Operation
Operand field encoding:
- bit 3 = indirect flag (I); bits 2:0 = location r, 0..7.
- Direct: location = r.
- Indirect: pointer = `mem[r][ADDR_WIDTH-1:0]`; location = pointer.

Per-opcode roles (unused outputs are driven to 0):
- MOV 0:
  - `dst_addr` ← A.
  - `src1` ← value(B).
  - If C == 4'b1000, `src1` ← `ir[15:0]` instead and B is not read.
- IN 1: `dst_addr` ← A.
- OUT 2: `src1` ← value(A).
- ADD/SUB/MUL/DIV 3..6: `dst_addr` ← A, `src1` ← value(B), `src2` ← value(C).
- STOP 7: nothing is read.
- 8..15: nothing is read; `illegal` = 1.

Read cost:
- Destination: 0 reads direct, 1 read indirect.
- Source: 1 read direct, 2 reads indirect.
- Immediate: 0 reads.

Fetch order is A, then B, then C; each operand's pointer read comes before its value read. The pointer value is truncated to ADDR_WIDTH.

On start acceptance:
- `ir` is copied internally, so later changes to `ir` have no effect.
- `dst_addr`, `src1`, `src2` and `illegal` are cleared.

States:
- IDLE
- ISSUE: load `mem_addr`
- WAIT
- CAPTURE: sample `mem_in`
- DONE

Transitions:
- IDLE → ISSUE on `start` when at least one read is needed.
- IDLE → DONE on `start` when no read is needed.
- CAPTURE → ISSUE if further reads remain, otherwise → DONE.
- DONE → IDLE unconditionally.

Boundary conditions:
- `start` while busy: ignored, not queued.
- `start` high in the DONE cycle: ignored.
- A self-pointing indirect operand (`mem[r]` = r) is legal and is read twice.

## Timing
- Reset values:
  - state IDLE, `mem_addr` = 0, `busy` = 0, `done` = 0, `illegal` = 0, `dst_addr` = 0, `src1` = 0, `src2` = 0.
- Reset mid-operation aborts immediately; no `done` follows.
- Memory contract: `mem_in` reflects `mem_addr` from two edges earlier. It is sampled at the end of CAPTURE, giving 3 cycles per read.
- Latency: with `start` sampled at edge E0, `done` is high during the cycle after edge E(3N), where N = number of reads. N = 0 gives `done` one cycle after E0.
- Results hold their values after `done` until the next accepted `start` or reset.
- `mem_addr` holds its last value while idle.

## Configuration
- `OPERAND_FETCH_INDIRECT_EN` defined: indirect addressing as described above.
- Undefined:
  - Bit 3 of A/B/C is ignored for addressing; every operand is treated as direct.
  - The MOV immediate check still compares the full C field against 4'b1000.
  - No pointer reads are ever issued.

## Test plan
- mem[1]=5, mem[2]=7; ir=0x3012_0000 (ADD A=0 B=1 C=2), start → `done` after 6 cycles; `src1`=5, `src2`=7, `dst_addr`=0.
- ir=0x0308_1234 (MOV A=3, immediate) → `done` the cycle after start; `src1`=0x1234, `dst_addr`=3, no ISSUE state visited.
- Macro on: mem[1]=0x0020, mem[0x20]=9, mem[2]=0x0011; ir=0x4A92_0000 (SUB A=ind 2, B=ind 1, C=dir 2) → `done` after 12 cycles; `dst_addr`=0x11, `src1`=9, `src2`=0x0011.
- Same ir with macro off → `done` after 6 cycles; `dst_addr`=2, `src1`=0x0020, `src2`=0x0011.
- Pulse `start` again mid-ADD, and change `ir` during the fetch → exactly one `done`; results match the originally latched ir.
- ir=0x9000_0000 → `done`+`illegal` one cycle after start. Separately, assert rst_n low during a WAIT state → all outputs 0 and IDLE at once; no `done` is produced.
